// File: rtl/grid_tile_painter_pkg.sv
// Shared frame-buffer geometry, colour codes and tile-origin helper used by the
// painter, the frame buffer and the VGA read side.
package grid_tile_painter_pkg;

    localparam int SCREEN_W   = 330;
    localparam int SCREEN_H   = 330;
    localparam int CELL_PX    = 30;
    localparam int GRID_CELLS = SCREEN_W / CELL_PX;
    localparam int ADDR_W     = 18;
    localparam int FB_WORDS   = SCREEN_W * SCREEN_H;

    typedef logic [ADDR_W-1:0] fb_addr_t;

    typedef enum logic [1:0] {
        CODE_BG       = 2'd0,
        CODE_WALL     = 2'd1,
        CODE_ROBOT    = 2'd2,
        CODE_GRIDLINE = 2'd3
    } color_code_t;

    localparam color_code_t BG_CODE = CODE_BG;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_PAINT = 2'd2
    } state_t;

    localparam fb_addr_t TILE_ROW_STEP = fb_addr_t'(CELL_PX * SCREEN_W);
    localparam fb_addr_t TILE_COL_STEP = fb_addr_t'(CELL_PX);

    // Constant multiplies only; evaluated once per accepted update.
    function automatic fb_addr_t tile_origin(input logic [3:0] cx, input logic [3:0] cy);
        return fb_addr_t'(cy) * TILE_ROW_STEP + fb_addr_t'(cx) * TILE_COL_STEP;
    endfunction

endpackage

// File: rtl/grid_tile_painter_if.sv
// Cell-update handshake plus frame-buffer write port of the tile painter.
// master = update producer / buffer consumer, slave = the painter.
interface grid_tile_painter_if;
    import grid_tile_painter_pkg::*;

    logic        upd_valid;
    logic        upd_ready;
    logic [3:0]  upd_x;
    logic [3:0]  upd_y;
    logic [1:0]  upd_code;
    logic        clear_req;
    fb_addr_t    w_addr;
    logic [1:0]  w_data;
    logic        w_en;
    logic        busy;
    logic        upd_err;

    modport master (
        output upd_valid, upd_x, upd_y, upd_code, clear_req,
        input  upd_ready, w_addr, w_data, w_en, busy, upd_err
    );

    modport slave (
        input  upd_valid, upd_x, upd_y, upd_code, clear_req,
        output upd_ready, w_addr, w_data, w_en, busy, upd_err
    );

endinterface

// File: rtl/grid_tile_painter_tile_addr_gen.sv
// Raster address walker for one 30x30 tile: row_base accumulation plus column offset.
// GRID_LINES_EN: when defined, flags tile border pixels so they can be drawn as grid lines.
module tile_addr_gen
    import grid_tile_painter_pkg::*;
(
    input  logic     clk_i,
    input  logic     rst_n_i,
    input  logic     load_i,
    input  logic     step_i,
    input  fb_addr_t origin_i,
    output fb_addr_t addr_o,
    output logic     last_o,
    output logic     on_grid_o
);

    localparam logic [4:0] LAST_IDX = 5'(CELL_PX - 1);

    fb_addr_t   row_base_q, row_base_d;
    logic [4:0] col_q, col_d;
    logic [4:0] rows_left_q, rows_left_d;
    logic       last_col, last_row;

    assign last_col = (col_q == LAST_IDX);
    assign last_row = (rows_left_q == 5'd0);
    assign last_o   = last_col && last_row;
    assign addr_o   = row_base_q + fb_addr_t'(col_q);

`ifdef GRID_LINES_EN
    assign on_grid_o = (col_q == 5'd0) || last_col || (rows_left_q == LAST_IDX) || last_row;
`else
    assign on_grid_o = 1'b0;
`endif

    // Holding on the last pixel keeps row_base from running past the frame end.
    always_comb begin
        row_base_d  = row_base_q;
        col_d       = col_q;
        rows_left_d = rows_left_q;
        if (load_i) begin
            row_base_d  = origin_i;
            col_d       = 5'd0;
            rows_left_d = LAST_IDX;
        end else if (step_i && !last_o) begin
            if (last_col) begin
                col_d       = 5'd0;
                row_base_d  = row_base_q + fb_addr_t'(SCREEN_W);
                rows_left_d = rows_left_q - 5'd1;
            end else begin
                col_d = col_q + 5'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            row_base_q  <= '0;
            col_q       <= 5'd0;
            rows_left_q <= LAST_IDX;
        end else begin
            row_base_q  <= row_base_d;
            col_q       <= col_d;
            rows_left_q <= rows_left_d;
        end
    end

endmodule

// File: rtl/grid_tile_painter.sv
// Expands maze cell updates into per-pixel frame-buffer writes; clears the screen first.
// Border colouring is selected by GRID_LINES_EN inside tile_addr_gen.
//
// state    | meaning
// ST_CLEAR | one BG write per cycle, addresses 0..FB_WORDS-1
// ST_IDLE  | ready for an update or a clear request
// ST_PAINT | 900 raster writes of the latched tile
module grid_tile_painter
    import grid_tile_painter_pkg::*;
(
    input  logic                clk_W,
    input  logic                reset_n,
    grid_tile_painter_if.slave  bus
);

    state_t      state_q, state_d;
    fb_addr_t    clr_addr_q, clr_addr_d;
    color_code_t code_q, code_d;
    fb_addr_t    w_addr_q, w_addr_d;
    color_code_t w_data_q, w_data_d;
    logic        w_en_q, w_en_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        err_q, err_d;

    logic        gen_load, gen_step, pix_last, pix_grid;
    fb_addr_t    pix_addr;
    logic        cell_ok, accept, clear_go;

    // upd_ready_q is only high in observable IDLE, so it gates both requests.
    assign cell_ok  = (bus.upd_x < 4'(GRID_CELLS)) && (bus.upd_y < 4'(GRID_CELLS));
    assign clear_go = ready_q && bus.clear_req;
    assign accept   = ready_q && bus.upd_valid && !bus.clear_req;

    tile_addr_gen u_addr_gen (
        .clk_i     (clk_W),
        .rst_n_i   (reset_n),
        .load_i    (gen_load),
        .step_i    (gen_step),
        .origin_i  (tile_origin(bus.upd_x, bus.upd_y)),
        .addr_o    (pix_addr),
        .last_o    (pix_last),
        .on_grid_o (pix_grid)
    );

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        code_d     = code_q;
        w_addr_d   = w_addr_q;
        w_data_d   = w_data_q;
        w_en_d     = 1'b0;
        err_d      = 1'b0;
        gen_load   = 1'b0;
        gen_step   = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                w_en_d     = 1'b1;
                w_addr_d   = clr_addr_q;
                w_data_d   = BG_CODE;
                clr_addr_d = clr_addr_q + fb_addr_t'(1);
                if (clr_addr_q == fb_addr_t'(FB_WORDS - 1)) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (clear_go) begin
                    state_d    = ST_CLEAR;
                    clr_addr_d = '0;
                end else if (accept) begin
                    if (cell_ok) begin
                        state_d  = ST_PAINT;
                        code_d   = color_code_t'(bus.upd_code);
                        gen_load = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_PAINT: begin
                w_en_d   = 1'b1;
                w_addr_d = pix_addr;
                w_data_d = pix_grid ? CODE_GRIDLINE : code_q;
                gen_step = 1'b1;
                if (pix_last) state_d = ST_IDLE;
            end
            default: begin
                state_d    = ST_CLEAR;
                clr_addr_d = '0;
            end
        endcase
        // The cycle carrying the final write still reports busy.
        ready_d = (state_d == ST_IDLE) && !w_en_d;
        busy_d  = !ready_d;
    end

    always_ff @(posedge clk_W) begin
        if (!reset_n) begin
            state_q    <= ST_CLEAR;
            clr_addr_q <= '0;
            code_q     <= CODE_BG;
            w_addr_q   <= '0;
            w_data_q   <= CODE_BG;
            w_en_q     <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b1;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            code_q     <= code_d;
            w_addr_q   <= w_addr_d;
            w_data_q   <= w_data_d;
            w_en_q     <= w_en_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    assign bus.upd_ready = ready_q;
    assign bus.w_addr    = w_addr_q;
    assign bus.w_data    = w_data_q;
    assign bus.w_en      = w_en_q;
    assign bus.busy      = busy_q;
    assign bus.upd_err   = err_q;

endmodule
